ibex_cheri_tagged_mem_responder: RTL and testbench
==================================================

// Module: ibex_cheri_tagged_mem_responder
// PURPOSE
//  Memory-side responder for the Ibex CHERI data interface (req/gnt/rvalid). Serves LSU word
//  accesses from a local RAM and keeps one tag bit per 8-byte capability slot.
//  Returns the slot tag on capability loads and sets/clears tags on stores.
//  Used as data memory in simulation/FPGA tops, opposite the core-side memory checker.
// PARAMETERS
//  MemBytes     65536         RAM size in bytes; power of two, >= 8
//  BaseAddr     32'h0010_0000 byte address of RAM word 0; MemBytes-aligned
//  ReadLatency  1             cycles from grant edge to rvalid; legal 1..4
// PORTS
//  clk_i          in   1   clock
//  rst_ni         in   1   reset, asynchronous, active-low
//  data_req_i     in   1   request valid
//  data_gnt_o     out  1   request accepted this cycle
//  data_rvalid_o  out  1   response valid, one per granted request
//  data_err_o     out  1   response is an error; qualified by rvalid
//  data_addr_i    in   32  word-aligned byte address
//  data_we_i      in   1   1 = store, 0 = load
//  data_be_i      in   4   byte enables
//  data_wdata_i   in   32  store data
//  data_cap_i     in   1   access is one beat of a capability access
//  data_wtag_i    in   1   tag to write; used on the second beat of a capability store
//  data_rdata_o   out  32  load data; 0 for stores and errors
//  data_rtag_o    out  1   slot tag for capability loads; 0 otherwise
//  stall_i        in   1   suppress grant (bench backpressure)
// BEHAVIOUR
//  - Grant: data_gnt_o = data_req_i & ~stall_i (combinational). One accept per cycle. No limit on outstanding requests.
//  - Index: off = addr - BaseAddr. Word = off[log2(MemBytes)-1:2]. Slot = off[log2(MemBytes)-1:3].
//    Beat = addr[2]: 0 = first beat, 1 = second beat.
//  - Store at the grant edge: write bytes enabled by data_be_i.
//    * Non-capability store: clears the slot tag.
//    * First beat of a capability store: clears the slot tag.
//    * Second beat of a capability store: sets tag := data_wtag_i.
//  - Load data and tag are sampled at the grant edge. A load granted the cycle after a store
//    to the same word returns the new data and tag.
//  - Capability beat with be != 4'hF is misaligned:
//    * err = 1, no RAM write, no tag change, rdata = 0, rtag = 0.
//  - Response pipeline: ReadLatency-stage shift register holding {valid, err, rdata, rtag}.
//    rvalid is asserted exactly ReadLatency cycles after the grant edge, in grant order.
//    Back-to-back grants give back-to-back rvalids.
//  - Stores also return rvalid, with rdata = 0 and rtag = 0.
//  - Non-capability load: rtag = 0. Capability load: rtag = slot tag on both beats.
//  - Reset:
//    * Outputs rvalid/err/rdata/rtag = 0; all tag bits = 0; pipeline cleared.
//    * RAM contents are not reset.
//    * Responses in flight are dropped; no rvalid is issued for them after reset.
//  - req while stall_i: no grant, no state change; the request must stay stable until granted.
// CONFIGURATION
//  IBEX_CHERI_TAGMEM_RANGE_ERR_EN
//   defined:  addr outside [BaseAddr, BaseAddr+MemBytes) is still granted.
//             Response has err = 1 with no write and no tag change.
//   undefined: the address is reduced modulo MemBytes (aliases into RAM); range errors never occur.
// TESTING
//  1 Reset, then load at BaseAddr+0x10 with data_cap_i=0 -> rvalid ReadLatency cycles after gnt; rtag = 0, err = 0.
//  2 Cap store 0x1111_1111 @ +0x20 (beat 0), then 0x2222_2222 @ +0x24 with wtag = 1;
//    then cap loads @ +0x20/+0x24 -> rdata 0x1111_1111 / 0x2222_2222, rtag = 1 on both beats.
//  3 After test 2, byte store be=4'b0010 @ +0x24 -> a cap load @ +0x20 returns rtag = 0; the other bytes are unchanged.
//  4 ReadLatency=3, 4 back-to-back loads with stall_i toggling every other cycle
//    -> 4 rvalids in grant order, each exactly 3 cycles after its grant.
//  5 Cap store be=4'b0011 @ +0x28 -> err = 1; the following cap load @ +0x28 shows rdata and rtag unchanged.
//  6 Assert rst_ni mid-burst with 2 responses in flight -> no rvalid after reset; all tags read 0.
//    With _RANGE_ERR_EN defined: load @ BaseAddr-4 -> err = 1.

Source files
------------

// File: rtl/ibex_cheri_tagged_mem_responder.sv
// Data-side memory responder for the Ibex CHERI LSU: word RAM plus one tag bit per 8-byte slot.
// Optional build macro IBEX_CHERI_TAGMEM_RANGE_ERR_EN turns out-of-window addresses into error responses.
module ibex_cheri_tagged_mem_responder #(
    parameter int unsigned MemBytes    = 65536,
    parameter logic [31:0] BaseAddr    = 32'h0010_0000,
    parameter int unsigned ReadLatency = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic        data_err_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    input  logic        data_cap_i,
    input  logic        data_wtag_i,
    output logic [31:0] data_rdata_o,
    output logic        data_rtag_o,
    input  logic        stall_i
);

    localparam int unsigned AW       = $clog2(MemBytes);
    localparam int unsigned WW       = AW - 2;
    localparam int unsigned SW       = (AW > 3) ? AW - 3 : 1;
    localparam int unsigned NumWords = MemBytes / 4;
    localparam int unsigned NumSlots = (MemBytes / 8 > 0) ? MemBytes / 8 : 1;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
        logic        rtag;
    } resp_t;

    logic [31:0]         mem [NumWords];
    logic [NumSlots-1:0] tag_q;
    resp_t               pipe_q [ReadLatency];
    resp_t               resp_d;

    logic [31:0]   off;
    logic [AW-1:0] off_m;
    logic [WW-1:0] word_idx;
    logic [SW-1:0] slot_idx;
    logic          beat;
    logic          cap_misalign;
    logic          range_err;
    logic          acc_err;
    logic          write_en;

    // Handshake: a request is accepted on every rising edge where req && gnt; the master holds
    // addr/we/be/wdata/cap/wtag stable while req is high and gnt is low. Each accepted request
    // yields exactly one rvalid pulse ReadLatency cycles later, in acceptance order; rvalid has
    // no ready and cannot be backpressured.
    assign data_gnt_o = data_req_i & ~stall_i;

    assign off      = data_addr_i - BaseAddr;
    assign off_m    = off[AW-1:0];
    assign word_idx = WW'(off_m >> 2);
    assign slot_idx = SW'(off_m >> 3);
    assign beat     = data_addr_i[2];

`ifdef IBEX_CHERI_TAGMEM_RANGE_ERR_EN
    assign range_err = (off >= 32'(MemBytes));
`else
    // Upper offset bits are dropped so the RAM aliases across the whole address space.
    logic unused_off;
    assign unused_off = ^off;
    assign range_err  = 1'b0;
`endif

    assign cap_misalign = data_cap_i & (data_be_i != 4'hF);
    assign acc_err      = cap_misalign | range_err;
    assign write_en     = data_gnt_o & data_we_i & ~acc_err;

    always_comb begin
        resp_d = '0;
        if (data_gnt_o) begin
            resp_d.valid = 1'b1;
            resp_d.err   = acc_err;
            if (!data_we_i && !acc_err) begin
                resp_d.rdata = mem[word_idx];
                resp_d.rtag  = data_cap_i & tag_q[slot_idx];
            end
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (write_en) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Only the second beat of a full capability store can set a tag; any other store clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_q <= '0;
        end else if (write_en) begin
            if (data_cap_i && beat) begin
                tag_q[slot_idx] <= data_wtag_i;
            end else begin
                tag_q[slot_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(ReadLatency); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= resp_d;
            for (int i = 1; i < int'(ReadLatency); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign data_rvalid_o = pipe_q[ReadLatency-1].valid;
    assign data_err_o    = pipe_q[ReadLatency-1].err;
    assign data_rdata_o  = pipe_q[ReadLatency-1].rdata;
    assign data_rtag_o   = pipe_q[ReadLatency-1].rtag;

endmodule

// File: tb/tb_ibex_cheri_tagged_mem_responder.sv
// Directed bench for ibex_cheri_tagged_mem_responder: vector table, stall and reset sequences.
module tb_ibex_cheri_tagged_mem_responder;

    localparam int unsigned LAT  = 3;
    localparam logic [31:0] BASE = 32'h0010_0000;
    localparam int unsigned MEMB = 65536;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        gnt;
    logic        rvalid;
    logic        err;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        cap;
    logic        wtag;
    logic [31:0] rdata;
    logic        rtag;
    logic        stall;

    ibex_cheri_tagged_mem_responder #(
        .MemBytes   (MEMB),
        .BaseAddr   (BASE),
        .ReadLatency(LAT)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .data_req_i   (req),
        .data_gnt_o   (gnt),
        .data_rvalid_o(rvalid),
        .data_err_o   (err),
        .data_addr_i  (addr),
        .data_we_i    (we),
        .data_be_i    (be),
        .data_wdata_i (wdata),
        .data_cap_i   (cap),
        .data_wtag_i  (wtag),
        .data_rdata_o (rdata),
        .data_rtag_o  (rtag),
        .stall_i      (stall)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    // {err, rtag, rdata, due_cycle}
    logic [65:0] exp_q[$];
    logic [65:0] e;

    typedef struct {
        logic [31:0] off;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        cap;
        logic        wtag;
        logic [31:0] exp_rdata;
        logic        exp_rtag;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [31:0] off, input logic w, input logic [3:0] b,
                                input logic [31:0] wd, input logic c, input logic t,
                                input logic [31:0] er, input logic et, input logic ee);
        vec_t v;
        v.off = off; v.we = w; v.be = b; v.wdata = wd; v.cap = c; v.wtag = t;
        v.exp_rdata = er; v.exp_rtag = et; v.exp_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rvalid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rvalid: got rvalid=1 expected none (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check("rsp_cycle", 32'(cyc), e[31:0]);
                check("rsp_rdata", rdata, e[63:32]);
                check("rsp_rtag", {31'b0, rtag}, {31'b0, e[64]});
                check("rsp_err", {31'b0, err}, {31'b0, e[65]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a falling edge; returns at the falling edge after the grant edge.
    task automatic issue(input vec_t v, input bit stall_first, input bit expect_rsp);
        int n;
        addr  = BASE + v.off;
        we    = v.we;
        be    = v.be;
        wdata = v.wdata;
        cap   = v.cap;
        wtag  = v.wtag;
        req   = 1'b1;
        if (stall_first) begin
            stall = 1'b1;
            #1;
            check("gnt_stalled", {31'b0, gnt}, 32'd0);
            @(negedge clk);
            stall = 1'b0;
        end
        #1;
        n = 0;
        while (!gnt && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("gnt", {31'b0, gnt}, 32'd1);
        if (gnt && expect_rsp) begin
            exp_q.push_back({v.exp_err, v.exp_rtag, v.exp_rdata, 32'(cyc + LAT)});
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rvalid"}, {31'b0, rvalid}, 32'd0);
        check({tag, "_err"}, {31'b0, err}, 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_rtag"}, {31'b0, rtag}, 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        req = 1'b0; we = 1'b0; be = 4'h0; wdata = '0; cap = 1'b0; wtag = 1'b0;
        addr = BASE; stall = 1'b0; rst_n = 1'b0;

        repeat (3) @(negedge clk);
        #1 check_idle_outputs("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_idle_outputs("after_reset");
        @(negedge clk);

        // off, we, be, wdata, cap, wtag, exp_rdata, exp_rtag, exp_err
        vecs.push_back(mk(32'h10, 1, 4'hF, 32'hA5A5_5A5A, 0, 0, 32'h0, 0, 0));
        vecs.push_back(mk(32'h10, 0, 4'hF, 32'h0,         0, 0, 32'hA5A5_5A5A, 0, 0));
        vecs.push_back(mk(32'h20, 1, 4'hF, 32'h1111_1111, 1, 0, 32'h0, 0, 0));
        vecs.push_back(mk(32'h24, 1, 4'hF, 32'h2222_2222, 1, 1, 32'h0, 0, 0));
        vecs.push_back(mk(32'h20, 0, 4'hF, 32'h0,         1, 0, 32'h1111_1111, 1, 0));
        vecs.push_back(mk(32'h24, 0, 4'hF, 32'h0,         1, 0, 32'h2222_2222, 1, 0));
        vecs.push_back(mk(32'h20, 0, 4'hF, 32'h0,         0, 0, 32'h1111_1111, 0, 0));
        vecs.push_back(mk(32'h24, 1, 4'h2, 32'h0000_AB00, 0, 0, 32'h0, 0, 0));
        vecs.push_back(mk(32'h24, 0, 4'hF, 32'h0,         1, 0, 32'h2222_AB22, 0, 0));
        vecs.push_back(mk(32'h20, 0, 4'hF, 32'h0,         1, 0, 32'h1111_1111, 0, 0));
        vecs.push_back(mk(32'h28, 1, 4'hF, 32'h3333_3333, 1, 1, 32'h0, 0, 0));
        vecs.push_back(mk(32'h2C, 1, 4'hF, 32'h4444_4444, 1, 1, 32'h0, 0, 0));
        vecs.push_back(mk(32'h28, 1, 4'h3, 32'hFFFF_FFFF, 1, 1, 32'h0, 0, 1));
        vecs.push_back(mk(32'h28, 0, 4'hF, 32'h0,         1, 0, 32'h3333_3333, 1, 0));
        vecs.push_back(mk(32'h2C, 0, 4'h5, 32'h0,         1, 0, 32'h0, 0, 1));
        vecs.push_back(mk(32'h2C, 0, 4'hF, 32'h0,         1, 0, 32'h4444_4444, 1, 0));
        vecs.push_back(mk(32'h30, 1, 4'hF, 32'hCAFE_BABE, 0, 0, 32'h0, 0, 0));
        vecs.push_back(mk(32'h30, 0, 4'hF, 32'h0,         0, 0, 32'hCAFE_BABE, 0, 0));
        vecs.push_back(mk(32'h2C, 1, 4'hF, 32'h5555_5555, 1, 0, 32'h0, 0, 0));
        vecs.push_back(mk(32'h28, 0, 4'hF, 32'h0,         1, 0, 32'h3333_3333, 0, 0));
        vecs.push_back(mk(32'h2C, 0, 4'hF, 32'h0,         1, 0, 32'h5555_5555, 0, 0));
`ifdef IBEX_CHERI_TAGMEM_RANGE_ERR_EN
        vecs.push_back(mk(MEMB + 32'h30, 0, 4'hF, 32'h0, 0, 0, 32'h0, 0, 1));
        vecs.push_back(mk(MEMB + 32'h30, 1, 4'hF, 32'h1234_5678, 0, 0, 32'h0, 0, 1));
        vecs.push_back(mk(32'h30, 0, 4'hF, 32'h0, 0, 0, 32'hCAFE_BABE, 0, 0));
`else
        vecs.push_back(mk(MEMB + 32'h30, 0, 4'hF, 32'h0, 0, 0, 32'hCAFE_BABE, 0, 0));
`endif

        // Table vectors go out back-to-back, so responses also stream back-to-back.
        foreach (vecs[i]) issue(vecs[i], 1'b0, 1'b1);
        drain();

        // Loads with one stalled cycle ahead of every grant.
        issue(mk(32'h10, 0, 4'hF, 32'h0, 0, 0, 32'hA5A5_5A5A, 0, 0), 1'b1, 1'b1);
        issue(mk(32'h20, 0, 4'hF, 32'h0, 1, 0, 32'h1111_1111, 0, 0), 1'b1, 1'b1);
        issue(mk(32'h2C, 0, 4'hF, 32'h0, 1, 0, 32'h5555_5555, 0, 0), 1'b1, 1'b1);
        issue(mk(32'h30, 0, 4'hF, 32'h0, 0, 0, 32'hCAFE_BABE, 0, 0), 1'b1, 1'b1);
        drain();

        // Set a tag, then reset with two loads in flight.
        issue(mk(32'h2C, 1, 4'hF, 32'h6666_6666, 1, 1, 32'h0, 0, 0), 1'b0, 1'b1);
        issue(mk(32'h2C, 0, 4'hF, 32'h0, 1, 0, 32'h6666_6666, 1, 0), 1'b0, 1'b1);
        drain();
        issue(mk(32'h2C, 0, 4'hF, 32'h0, 1, 0, 32'h0, 0, 0), 1'b0, 1'b0);
        issue(mk(32'h20, 0, 4'hF, 32'h0, 1, 0, 32'h0, 0, 0), 1'b0, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        #1 check_idle_outputs("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1 check("post_reset_rvalid", {31'b0, rvalid}, 32'd0);
            @(negedge clk);
        end

        issue(mk(32'h20, 0, 4'hF, 32'h0, 1, 0, 32'h1111_1111, 0, 0), 1'b0, 1'b1);
        issue(mk(32'h24, 0, 4'hF, 32'h0, 1, 0, 32'h2222_AB22, 0, 0), 1'b0, 1'b1);
        issue(mk(32'h28, 0, 4'hF, 32'h0, 1, 0, 32'h3333_3333, 0, 0), 1'b0, 1'b1);
        issue(mk(32'h2C, 0, 4'hF, 32'h0, 1, 0, 32'h6666_6666, 0, 0), 1'b0, 1'b1);
`ifdef IBEX_CHERI_TAGMEM_RANGE_ERR_EN
        issue(mk(32'hFFFF_FFFC, 0, 4'hF, 32'h0, 0, 0, 32'h0, 0, 1), 1'b0, 1'b1);
`endif
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case a wait never resolves.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
